// File: rtl/mvm_pkg.sv
// Shared types and defaults for the matrix-vector multiply sequencer.
package mvm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_X,
        LOAD_A,
        CLEAR,
        MAC,
        DRAIN,
        WRITE,
        OUTPUT
    } mvm_state_t;

    localparam int MVM_M       = 3;
    localparam int MVM_N       = 3;
    localparam int MVM_MAC_LAT = 2;

    // Counter/address width for a range of n values; never narrower than 1 bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mvm_counter.sv
// Up-counter with terminal-value flag; returns to zero after its terminal value
// so it is ready for the next pass without an explicit clear.
module mvm_counter
    import mvm_pkg::*;
#(
    parameter int W    = 4,
    parameter int TERM = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         term
);

    assign term = (count == W'(TERM));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= term ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/mvm_seq_ctrl.sv
// Control sequencer for a matrix-vector multiply: load X and a, MAC each row, stream y.
// Optional feature macro MVM_REUSE_X_EN adds start_vec to rerun with the stored matrix.
module mvm_seq_ctrl
    import mvm_pkg::*;
#(
    parameter int M       = MVM_M,
    parameter int N       = MVM_N,
    parameter int MAC_LAT = MVM_MAC_LAT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
`ifdef MVM_REUSE_X_EN
    input  logic                    start_vec,
`endif
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    wr_en_x,
    output logic [cnt_w(M*N)-1:0]   addr_x,
    output logic                    wr_en_a,
    output logic [cnt_w(N)-1:0]     addr_a,
    output logic                    wr_en_y,
    output logic [cnt_w(M)-1:0]     addr_y,
    output logic                    clear_acc,
    output logic                    en_acc,
    output logic                    out_valid,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done
);

    localparam int XW         = cnt_w(M*N);
    localparam int AW         = cnt_w(N);
    localparam int YW         = cnt_w(M);
    localparam int DW         = cnt_w(MAC_LAT);
    localparam int DRAIN_TERM = (MAC_LAT > 0) ? MAC_LAT - 1 : 0;

    mvm_state_t    state, state_next;

    logic [XW-1:0] load_cnt;
    logic          load_term;
    logic [AW-1:0] col_cnt;
    logic          col_term;
    logic [YW-1:0] row_cnt;
    logic          row_term;
    logic [YW-1:0] out_cnt;
    logic          out_term;
    logic [DW-1:0] drain_cnt;
    logic          drain_last;
    logic          loading;
    logic          load_a_last;
    logic [XW-1:0] mac_addr;

    assign loading     = (state == LOAD_X) || (state == LOAD_A);
    assign load_a_last = (state == LOAD_A) && in_valid && (load_cnt == XW'(N - 1));
    assign mac_addr    = XW'(row_cnt) * XW'(N) + XW'(col_cnt);
    assign drain_last  = (drain_cnt == DW'(DRAIN_TERM));
    assign busy        = (state != IDLE);

    // The load counter serves both X and a; the a phase ends early at N-1.
    mvm_counter #(.W(XW), .TERM(M*N - 1)) u_load_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (load_a_last),
        .en    (loading && in_valid),
        .count (load_cnt),
        .term  (load_term)
    );

    mvm_counter #(.W(AW), .TERM(N - 1)) u_col_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .en    (state == MAC),
        .count (col_cnt),
        .term  (col_term)
    );

    mvm_counter #(.W(YW), .TERM(M - 1)) u_row_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .en    (state == WRITE),
        .count (row_cnt),
        .term  (row_term)
    );

    mvm_counter #(.W(YW), .TERM(M - 1)) u_out_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .en    ((state == OUTPUT) && out_ready),
        .count (out_cnt),
        .term  (out_term)
    );

    always_ff @(posedge clk) begin
        if (reset || (state != DRAIN)) begin
            drain_cnt <= '0;
        end else begin
            drain_cnt <= drain_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state == OUTPUT) && out_ready && out_term;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        wr_en_x    = 1'b0;
        addr_x     = '0;
        wr_en_a    = 1'b0;
        addr_a     = '0;
        wr_en_y    = 1'b0;
        addr_y     = '0;
        clear_acc  = 1'b0;
        en_acc     = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD_X;
`ifdef MVM_REUSE_X_EN
                end else if (start_vec) begin
                    state_next = LOAD_A;
`endif
                end
            end
            LOAD_X: begin
                in_ready = 1'b1;
                wr_en_x  = in_valid;
                addr_x   = load_cnt;
                if (in_valid && load_term) begin
                    state_next = LOAD_A;
                end
            end
            LOAD_A: begin
                in_ready = 1'b1;
                wr_en_a  = in_valid;
                addr_a   = AW'(load_cnt);
                if (load_a_last) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                clear_acc  = 1'b1;
                state_next = MAC;
            end
            MAC: begin
                en_acc = 1'b1;
                addr_x = mac_addr;
                addr_a = col_cnt;
                if (col_term) begin
                    state_next = (MAC_LAT == 0) ? WRITE : DRAIN;
                end
            end
            DRAIN: begin
                if (drain_last) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                wr_en_y    = 1'b1;
                addr_y     = row_cnt;
                state_next = row_term ? OUTPUT : CLEAR;
            end
            OUTPUT: begin
                out_valid = 1'b1;
                addr_y    = out_cnt;
                out_last  = out_term;
                if (out_ready && out_term) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: doc/mvm_seq_ctrl.md
MVM_SEQ_CTRL -- requirements
Module: mvm_seq_ctrl

Interface
REQ-001 SHALL have parameter M, default 3, matrix rows / output vector length.
REQ-002 SHALL have parameter N, default 3, matrix columns / input vector length.
REQ-003 SHALL have parameter MAC_LAT, default 2, MAC pipeline drain cycles (0 legal).
REQ-004 clk  input  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 start  input  1  begin full job (load matrix, load vector, compute, output).
REQ-007 in_valid / in_ready  input / output  1 / 1  load-stream handshake, one word per beat.
REQ-008 wr_en_x, addr_x  output  1, clog2(M*N)  matrix memory write enable / address (row-major).
REQ-009 wr_en_a, addr_a  output  1, clog2(N)  vector memory write enable / address.
REQ-010 wr_en_y, addr_y  output  1, clog2(M)  result memory write enable / address.
REQ-011 clear_acc, en_acc  output  1 / 1  accumulator clear / accumulate enable.
REQ-012 out_valid, out_last / out_ready  output / input  1 each  result-stream handshake; result data is combinational read of y at addr_y.
REQ-013 busy, done  output  1 / 1  job in progress / one-cycle completion pulse.

Function
REQ-014 States SHALL be IDLE, LOAD_X, LOAD_A, CLEAR, MAC, DRAIN, WRITE, OUTPUT.
REQ-015 IDLE: start=1 -> LOAD_X next cycle; start in any other state ignored.
REQ-016 LOAD_X: in_ready=1; wr_en_x=in_valid; addr_x=load count 0..M*N-1, advancing only on in_valid&in_ready; beat M*N-1 accepted -> LOAD_A.
REQ-017 LOAD_A: in_ready=1; wr_en_a=in_valid; addr_a=load count 0..N-1; beat N-1 accepted -> CLEAR with row=0.
REQ-018 CLEAR: clear_acc=1 for exactly one cycle -> MAC with col=0.
REQ-019 MAC: en_acc=1, addr_x=row*N+col, addr_a=col for N consecutive cycles; col=N-1 -> DRAIN (or WRITE if MAC_LAT=0).
REQ-020 DRAIN: exactly MAC_LAT cycles, all enables 0 -> WRITE.
REQ-021 WRITE: wr_en_y=1, addr_y=row for one cycle; row=M-1 -> OUTPUT with out count 0, else row+1 -> CLEAR.
REQ-022 OUTPUT: out_valid=1, addr_y=out count, out_last=(count==M-1); count advances on out_valid&out_ready; last accepted -> IDLE with done=1 that cycle of transition's next cycle (first IDLE cycle).
REQ-023 out_valid SHALL stay high and addr_y stable while out_ready=0 (no drop under backpressure).
REQ-024 in_ready SHALL be 0 outside LOAD_X/LOAD_A; in_valid gaps stall loading without skipping addresses.
REQ-025 busy = (state != IDLE); done never coincident with busy.
REQ-026 Counters SHALL use clog2-sized unsigned arithmetic; no counter wraps past its terminal value.
REQ-027 Outputs not named active in a state SHALL be 0; addresses SHALL be 0 when unused.
REQ-028 Fully streamed job SHALL take M*N + N + M*(N+MAC_LAT+2) cycles from first LOAD_X cycle to first OUTPUT cycle.

Reset
REQ-029 reset SHALL force IDLE, all counters 0, all outputs 0, from any state including mid-load, mid-MAC and mid-OUTPUT; no done pulse on reset.

Configuration
REQ-030 MVM_REUSE_X_EN defined: input port start_vec (1 bit) SHALL exist; start_vec in IDLE (start=0) -> LOAD_A directly, reusing stored matrix; start has priority if both high.
REQ-031 MVM_REUSE_X_EN undefined: start_vec port absent; only start launches jobs.

Structure
REQ-032 Package mvm_pkg SHALL hold state enum mvm_state_t and default M, N, MAC_LAT constants.
REQ-033 Sub-module mvm_counter (parameterized width, terminal value, enable, clear, terminal flag) SHALL implement load, col, row and out counters.

Verification
REQ-034 M=N=3, MAC_LAT=2, continuous in_valid, out_ready=1: first OUTPUT 33 cycles after LOAD_X entry; addr_x 0..8 then addr_a 0..2 written.
REQ-035 in_valid toggling every other cycle during load: 12 writes total, addresses contiguous, no duplicates.
REQ-036 out_ready low 4 cycles at count 1: out_valid held, addr_y=1 held, out_last only at addr_y=2, done pulses once.
REQ-037 reset asserted during MAC row 1: next cycle IDLE, busy=0, all enables 0; new start completes normal job.
REQ-038 MAC_LAT=0: WRITE directly follows last MAC cycle; per-row period N+2 cycles.
REQ-039 MVM_REUSE_X_EN defined, start_vec after a job: no wr_en_x pulses, 3 vector writes, correct 3 results.
